// File: rtl/alu_unit_pkg.sv
// Shared op-code encoding and constants for the integer execution lane.
package alu_unit_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int ROB_W_DEF = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Op codes not listed here, such as the memory ops, complete with a zero result.
  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_BNE   = 6'd6,
    OP_BLT   = 6'd7,
    OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,
    OP_BGEU  = 6'd10,
    OP_ADDI  = 6'd11,
    OP_SLTI  = 6'd12,
    OP_SLTIU = 6'd13,
    OP_XORI  = 6'd14,
    OP_ORI   = 6'd15,
    OP_ANDI  = 6'd16,
    OP_SLLI  = 6'd17,
    OP_SRLI  = 6'd18,
    OP_SRAI  = 6'd19,
    OP_ADD   = 6'd20,
    OP_SUB   = 6'd21,
    OP_SLL   = 6'd22,
    OP_SLT   = 6'd23,
    OP_SLTU  = 6'd24,
    OP_XOR   = 6'd25,
    OP_SRL   = 6'd26,
    OP_SRA   = 6'd27,
    OP_OR    = 6'd28,
    OP_AND   = 6'd29
  } alu_op_e;

  // The -I forms take their second operand from the immediate instead of rs2.
  function automatic logic uses_imm(input logic [5:0] op);
    return op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                      OP_SLLI, OP_SRLI, OP_SRAI};
  endfunction

endpackage

// File: rtl/alu_unit_if.sv
// Dispatch bus from the reservation station and the ALU lane of the CDB.
interface alu_unit_if #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4
);
  logic             alu_enable;
  logic [5:0]       alu_op;
  logic [XLEN-1:0]  alu_vj;
  logic [XLEN-1:0]  alu_vk;
  logic [XLEN-1:0]  alu_imm;
  logic [ROB_W-1:0] alu_rd_tag;
  logic [XLEN-1:0]  alu_pc;

  logic             cdb_valid;
  logic [XLEN-1:0]  cdb_result;
  logic [ROB_W-1:0] cdb_rd_tag;
  logic             cdb_jump;
  logic [XLEN-1:0]  cdb_target;

  modport master (
    output alu_enable, alu_op, alu_vj, alu_vk, alu_imm, alu_rd_tag, alu_pc,
    input  cdb_valid, cdb_result, cdb_rd_tag, cdb_jump, cdb_target
  );

  modport slave (
    input  alu_enable, alu_op, alu_vj, alu_vk, alu_imm, alu_rd_tag, alu_pc,
    output cdb_valid, cdb_result, cdb_rd_tag, cdb_jump, cdb_target
  );
endinterface

// File: rtl/alu_unit_comb.sv
// Combinational core: integer result plus branch/jump resolution for one op.
module alu_comb
  import alu_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      op_i,
  input  logic [XLEN-1:0] vj_i,
  input  logic [XLEN-1:0] vk_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] result_o,
  output logic            jump_o,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic            b_eq, b_lt_s, b_lt_u;
  logic            lt_s, lt_u;
  alu_op_e         op_e;

  assign op_e        = alu_op_e'(op_i);
  assign op_b        = uses_imm(op_i) ? imm_i : vk_i;
  assign shamt       = op_b[4:0];
  assign pc_plus4    = pc_i + XLEN'(4);
  assign pc_plus_imm = pc_i + imm_i;

  // Compares for SLT*/SLTU* use op_b; branches always compare rs1 against rs2.
  assign lt_s   = $signed(vj_i) < $signed(op_b);
  assign lt_u   = vj_i < op_b;
  assign b_eq   = vj_i == vk_i;
  assign b_lt_s = $signed(vj_i) < $signed(vk_i);
  assign b_lt_u = vj_i < vk_i;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    result_o = '0;
    jump_o   = FALSE;
    target_o = pc_plus4;
    unique case (op_e)
      OP_ADD, OP_ADDI:   result_o = vj_i + op_b;
      OP_SUB:            result_o = vj_i - vk_i;
      OP_AND, OP_ANDI:   result_o = vj_i & op_b;
      OP_OR,  OP_ORI:    result_o = vj_i | op_b;
      OP_XOR, OP_XORI:   result_o = vj_i ^ op_b;
      OP_SLT, OP_SLTI:   result_o = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU, OP_SLTIU: result_o = {{(XLEN-1){1'b0}}, lt_u};
      OP_SLL, OP_SLLI:   result_o = vj_i << shamt;
      OP_SRL, OP_SRLI:   result_o = vj_i >> shamt;
      OP_SRA, OP_SRAI:   result_o = $unsigned($signed(vj_i) >>> shamt);
      OP_LUI:            result_o = imm_i;
      OP_AUIPC:          result_o = pc_plus_imm;
      OP_JAL: begin
        result_o = pc_plus4;
        jump_o   = TRUE;
        target_o = pc_plus_imm;
      end
      OP_JALR: begin
        result_o = pc_plus4;
        jump_o   = TRUE;
        target_o = (vj_i + imm_i) & ~XLEN'(1);
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (op_e)
          OP_BEQ:  jump_o = b_eq;
          OP_BNE:  jump_o = !b_eq;
          OP_BLT:  jump_o = b_lt_s;
          OP_BGE:  jump_o = !b_lt_s;
          OP_BLTU: jump_o = b_lt_u;
          default: jump_o = !b_lt_u;
        endcase
        if (jump_o) target_o = pc_plus_imm;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// ALU execution lane: combinational core plus the registered CDB broadcast,
// with global-enable hold and misprediction kill.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int ROB_W = ROB_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       rollback,
  alu_unit_if.slave  bus
);

  logic [XLEN-1:0]  comb_result;
  logic             comb_jump;
  logic [XLEN-1:0]  comb_target;

  logic             valid_q,  valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [ROB_W-1:0] tag_q,    tag_d;
  logic             jump_q,   jump_d;
  logic [XLEN-1:0]  target_q, target_d;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .op_i     (bus.alu_op),
    .vj_i     (bus.alu_vj),
    .vk_i     (bus.alu_vk),
    .imm_i    (bus.alu_imm),
    .pc_i     (bus.alu_pc),
    .result_o (comb_result),
    .jump_o   (comb_jump),
    .target_o (comb_target)
  );

  // Payload only loads on a dispatch so an idle lane keeps its last broadcast.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    tag_d    = tag_q;
    jump_d   = jump_q;
    target_d = target_q;
    if (rdy) begin
      valid_d = bus.alu_enable && !rollback;
      if (bus.alu_enable) begin
        result_d = comb_result;
        tag_d    = bus.alu_rd_tag;
        jump_d   = comb_jump;
        target_d = comb_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      valid_q  <= FALSE;
      result_q <= '0;
      tag_q    <= '0;
      jump_q   <= FALSE;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      jump_q   <= jump_d;
      target_q <= target_d;
    end
  end

  assign bus.cdb_valid  = valid_q;
  assign bus.cdb_result = result_q;
  assign bus.cdb_rd_tag = tag_q;
  assign bus.cdb_jump   = jump_q;
  assign bus.cdb_target = target_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit with hand-computed CDB expectations.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, rollback;
  int   checks = 0;
  int   errors = 0;

  alu_unit_if #(.XLEN(32), .ROB_W(4)) bus ();

  alu_unit #(.XLEN(32), .ROB_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic expect_cdb(input string name, input logic v, input logic [31:0] res,
                            input logic [3:0] tag, input logic j, input logic [31:0] tgt);
    check({name, ".valid"},  {31'd0, bus.cdb_valid}, {31'd0, v});
    check({name, ".result"}, bus.cdb_result, res);
    check({name, ".tag"},    {28'd0, bus.cdb_rd_tag}, {28'd0, tag});
    check({name, ".jump"},   {31'd0, bus.cdb_jump}, {31'd0, j});
    check({name, ".target"}, bus.cdb_target, tgt);
  endtask

  task automatic drive(input logic en, input alu_op_e op, input logic [31:0] vj,
                       input logic [31:0] vk, input logic [31:0] imm,
                       input logic [3:0] tag, input logic [31:0] pc);
    bus.alu_enable = en;
    bus.alu_op     = op;
    bus.alu_vj     = vj;
    bus.alu_vk     = vk;
    bus.alu_imm    = imm;
    bus.alu_rd_tag = tag;
    bus.alu_pc     = pc;
  endtask

  // Advance one edge and settle just after it, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    drive(1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0);
    step(); step();
    expect_cdb("reset", 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);

    rst = 1'b0;
    step();
    check("idle1.valid", {31'd0, bus.cdb_valid}, 32'd0);
    step();
    expect_cdb("idle2", 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);

    drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h2, 32'h0, 4'd5, 32'h1000);
    step();
    expect_cdb("add_ovf", 1'b1, 32'h1, 4'd5, 1'b0, 32'h1004);
    drive(1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0);
    step();
    check("add_onepulse.valid", {31'd0, bus.cdb_valid}, 32'd0);
    check("add_hold.tag", {28'd0, bus.cdb_rd_tag}, 32'd5);

    drive(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'd6, 32'h10);
    step();
    expect_cdb("slt", 1'b1, 32'h1, 4'd6, 1'b0, 32'h14);
    drive(1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'd7, 32'h10);
    step();
    check("sltu.result", bus.cdb_result, 32'h0);
    drive(1'b1, OP_SRA, 32'h8000_0000, 32'h21, 32'h0, 4'd8, 32'h10);
    step();
    check("sra.result", bus.cdb_result, 32'hC000_0000);
    drive(1'b1, OP_SRLI, 32'h8000_0000, 32'h0, 32'h4, 4'd8, 32'h10);
    step();
    check("srli.result", bus.cdb_result, 32'h0800_0000);
    drive(1'b1, OP_SUB, 32'h5, 32'h7, 32'h0, 4'd9, 32'h10);
    step();
    check("sub.result", bus.cdb_result, 32'hFFFF_FFFE);
    drive(1'b1, OP_XORI, 32'hF0F0_1234, 32'h0, 32'hFFFF_FFFF, 4'd9, 32'h10);
    step();
    check("xori.result", bus.cdb_result, 32'h0F0F_EDCB);
    drive(1'b1, OP_SLLI, 32'h0000_0003, 32'h0, 32'h0000_0004, 4'd9, 32'h10);
    step();
    check("slli.result", bus.cdb_result, 32'h30);
    drive(1'b1, OP_LUI, 32'h0, 32'h0, 32'h1234_5000, 4'd10, 32'h10);
    step();
    check("lui.result", bus.cdb_result, 32'h1234_5000);
    drive(1'b1, OP_AUIPC, 32'h0, 32'h0, 32'h2000, 4'd11, 32'h1000);
    step();
    expect_cdb("auipc", 1'b1, 32'h3000, 4'd11, 1'b0, 32'h1004);

    drive(1'b1, OP_BLT, 32'hFFFF_FFFD, 32'h2, 32'hFFFF_FFF8, 4'd12, 32'h100);
    step();
    expect_cdb("blt_taken", 1'b1, 32'h0, 4'd12, 1'b1, 32'hF8);
    drive(1'b1, OP_BGEU, 32'h1, 32'h2, 32'hFFFF_FFF8, 4'd13, 32'h100);
    step();
    expect_cdb("bgeu_nt", 1'b1, 32'h0, 4'd13, 1'b0, 32'h104);
    drive(1'b1, OP_BGE, 32'hFFFF_FFFD, 32'h2, 32'h20, 4'd13, 32'h100);
    step();
    check("bge_nt.jump", {31'd0, bus.cdb_jump}, 32'd0);
    drive(1'b1, OP_BLTU, 32'hFFFF_FFFD, 32'h2, 32'h20, 4'd13, 32'h100);
    step();
    check("bltu_nt.jump", {31'd0, bus.cdb_jump}, 32'd0);
    drive(1'b1, OP_BEQ, 32'h55, 32'h55, 32'h20, 4'd14, 32'h100);
    step();
    expect_cdb("beq_taken", 1'b1, 32'h0, 4'd14, 1'b1, 32'h120);
    drive(1'b1, OP_BNE, 32'h55, 32'h55, 32'h20, 4'd14, 32'h100);
    step();
    check("bne_nt.target", bus.cdb_target, 32'h104);
    drive(1'b1, OP_JALR, 32'h203, 32'h0, 32'h0, 4'd15, 32'h40);
    step();
    expect_cdb("jalr", 1'b1, 32'h44, 4'd15, 1'b1, 32'h202);
    drive(1'b1, OP_JAL, 32'h0, 32'h0, 32'h10, 4'd2, 32'h40);
    step();
    expect_cdb("jal", 1'b1, 32'h44, 4'd2, 1'b1, 32'h50);
    drive(1'b1, alu_op_e'(6'd63), 32'h1, 32'h2, 32'h3, 4'd7, 32'h200);
    step();
    expect_cdb("unknown", 1'b1, 32'h0, 4'd7, 1'b0, 32'h204);

    drive(1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0);
    step();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, OP_ADDI, 32'h100, 32'h0, 32'(i), 4'(i), 32'h300);
      step();
      check($sformatf("b2b%0d.valid", i), {31'd0, bus.cdb_valid}, 32'd1);
      check($sformatf("b2b%0d.tag", i), {28'd0, bus.cdb_rd_tag}, 32'(i));
      check($sformatf("b2b%0d.result", i), bus.cdb_result, 32'h100 + 32'(i));
    end
    drive(1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0);
    step();
    check("b2b_end.valid", {31'd0, bus.cdb_valid}, 32'd0);

    drive(1'b1, OP_ADD, 32'h1, 32'h1, 32'h0, 4'd4, 32'h0);
    rollback = 1'b1;
    step();
    check("rollback.valid", {31'd0, bus.cdb_valid}, 32'd0);
    rollback = 1'b0;

    drive(1'b1, OP_OR, 32'h00F0, 32'h0F00, 32'h0, 4'd9, 32'h80);
    step();
    expect_cdb("pre_hold", 1'b1, 32'h0FF0, 4'd9, 1'b0, 32'h84);
    drive(1'b1, OP_JAL, 32'h0, 32'h0, 32'h40, 4'd10, 32'h500);
    rdy = 1'b0;
    step();
    expect_cdb("rdy_hold", 1'b1, 32'h0FF0, 4'd9, 1'b0, 32'h84);
    rdy = 1'b1;
    drive(1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 4'd0, 32'h0);
    step();
    check("post_hold.valid", {31'd0, bus.cdb_valid}, 32'd0);
    check("post_hold.tag", {28'd0, bus.cdb_rd_tag}, 32'd9);

    drive(1'b1, OP_AND, 32'hFF00, 32'h0FF0, 32'h0, 4'd3, 32'h0);
    rst = 1'b1; rollback = 1'b1;
    step();
    expect_cdb("rst_prio", 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Integer execution unit directly downstream of the reservation station.
- Accepts at most one ready instruction per cycle, as operands, immediate, pc, ROB tag and op code.
- Computes the arithmetic, logic or compare result plus branch/jump resolution, and registers it onto the ALU lane of the CDB.
- The CDB lane is consumed by the RS wakeup logic, the LSB and the ROB.

Parameters:
- ROB_W, 4, width of the ROB tag (matches `ROBRange).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low all state holds
- rollback  in  1  ROB misprediction flush
- alu_enable  in  1  RS dispatch valid this cycle
- alu_op  in  6  op code (shared encoding)
- alu_vj  in  XLEN  rs1 value
- alu_vk  in  XLEN  rs2 value
- alu_imm  in  XLEN  sign-extended immediate
- alu_rd_tag  in  ROB_W  destination ROB tag
- alu_pc  in  XLEN  instruction pc
- cdb_valid  out  1  result broadcast valid
- cdb_result  out  XLEN  rd write value
- cdb_rd_tag  out  ROB_W  tag of broadcast
- cdb_jump  out  1  control transfer actually taken
- cdb_target  out  XLEN  resolved next pc when cdb_jump=1, else pc+4

Behaviour:
- Reset (rst=1 at posedge):
  - cdb_valid=0, cdb_result=0, cdb_rd_tag=0, cdb_jump=0, cdb_target=0.
  - rst has priority over rollback and rdy.
- Latency and capture:
  - One cycle, no backpressure; a new op is accepted every cycle.
  - alu_enable=1 at edge N (rdy=1): result visible in cycle N+1.
  - cdb_valid is high for exactly that one cycle unless alu_enable is again high at edge N+1.
- rdy=0: all output registers hold, and the input of that cycle is dropped. The RS also holds when rdy=0, so nothing is lost.
- Rollback:
  - rollback=1 at an edge: cdb_valid<=0 regardless of alu_enable; the other outputs are don't-care.
  - An op already broadcast before the edge is unaffected.
- Integer ops (results masked to XLEN):
  - ADD/ADDI, SUB: wrap-around, modulo 2^32.
  - AND/OR/XOR (and the -I forms).
  - SLT/SLTI: signed compare. SLTU/SLTIU: unsigned compare. Result is 1 or 0.
  - SLL/SRL/SRA (and the -I forms): shift amount = low 5 bits of vk or imm. SRA is arithmetic.
  - LUI: result=imm.
  - AUIPC: result=pc+imm.
- Integer ops outputs: cdb_jump=0, cdb_target=pc+4.
- JAL:
  - result=pc+4, cdb_jump=1, target=pc+imm.
- JALR:
  - result=pc+4, cdb_jump=1, target=(vj+imm)&~1.
- Branches (BEQ, BNE, BLT, BGE signed; BLTU, BGEU unsigned):
  - result=0; cdb_valid still 1 so the ROB entry completes.
  - taken: cdb_jump=1, target=pc+imm.
  - not taken: cdb_jump=0, target=pc+4.
  - The ROB compares cdb_jump with its prediction.
- Unknown op: cdb_valid=1, result=0, jump=0, target=pc+4. The ROB tag is never lost.
- cdb_rd_tag always equals the tag captured with the op.
- The unit holds no operand state between ops beyond the output registers.

Decomposition:
- Shared package (defines.v):
  - 6-bit op code constants, e.g. OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ..OP_BGEU, OP_ADD..OP_AND, OP_ADDI..OP_SRAI.
  - `ROBRange, `True/`False.
- Sub-module alu_comb: purely combinational.
  - Inputs: op, vj, vk, imm, pc.
  - Outputs: result, jump, target.
- alu_unit wraps alu_comb with the output register, rdy gating and rollback kill.

Test Plan:
- Reset then idle: rst=1 two cycles, alu_enable=0 -> all outputs 0, cdb_valid never rises.
- ADD overflow: vj=0xFFFFFFFF, vk=2, tag=5 -> next cycle cdb_valid=1, result=0x00000001, tag=5, jump=0, target=pc+4.
- Signed vs unsigned and shift:
  - SLT vj=0xFFFFFFFF, vk=1 -> result 1; SLTU with the same operands -> result 0.
  - SRA vj=0x80000000, vk=0x21 -> result 0xC0000000.
- Branches and JALR:
  - BLT vj=-3, vk=2, pc=0x100, imm=-8 -> jump=1, target=0xF8.
  - BGEU vj=1, vk=2 -> jump=0, target=0x104.
  - JALR vj=0x203, imm=0, pc=0x40 -> result 0x44, target 0x202.
- Back-to-back dispatch: three enables on consecutive edges, tags 1,2,3 -> cdb_valid high three consecutive cycles with tags 1,2,3 in order.
- Rollback and rdy:
  - alu_enable=1 with rollback=1 at the same edge -> cdb_valid=0 next cycle.
  - rdy=0 with alu_enable=1 -> outputs unchanged from previous cycle.
